// File: rtl/upsampling.sv
// ============================================================================
// upsampling : linear-interpolating 8-bit upsampler, 2^SHIFT outputs per input
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module upsampling #(
  parameter int SHIFT = 3
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iData,
  input  logic       iData_Valid,
  output logic [7:0] oData,
  output logic       oData_Valid,
  output logic       oBusy,
  output logic       oOverflow
);

  localparam int AW = 9 + SHIFT;
  localparam int KW = SHIFT + 1;
  localparam logic [KW-1:0] K_TAIL = KW'(1 << SHIFT);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [7:0]    prev_q, prev_d;
  logic [7:0]    tgt_q, tgt_d;
  logic [8:0]    delta_q, delta_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [KW-1:0] k_q, k_d;
  logic          pend_full_q, pend_full_d;
  logic [7:0]    pend_q, pend_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;

  // k_q counts 1..F; k_q == F is the cycle showing the last output of a burst,
  // which is also where the next burst (pending or fresh) is launched.
  logic       run_tail;
  logic       start;
  logic [7:0] start_base;
  logic [7:0] start_new;
  logic [8:0] start_delta;

  always_comb begin
    run_tail    = (state_q == S_RUN) && (k_q == K_TAIL);
    start       = ((state_q == S_IDLE) && iData_Valid) ||
                  (run_tail && (pend_full_q || iData_Valid));
    start_base  = run_tail ? tgt_q : prev_q;
    start_new   = (run_tail && pend_full_q) ? pend_q : iData;
    start_delta = {1'b0, start_new} - {1'b0, start_base};
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= S_EMPTY;
      prev_q      <= '0;
      tgt_q       <= '0;
      delta_q     <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      pend_full_q <= 1'b0;
      pend_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      tgt_q       <= tgt_d;
      delta_q     <= delta_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (iData_Valid) state_d = S_IDLE;
      S_IDLE:  if (iData_Valid) state_d = S_RUN;
      S_RUN:   if (run_tail && !start) state_d = S_IDLE;
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    prev_d      = prev_q;
    tgt_d       = tgt_q;
    delta_d     = delta_q;
    acc_d       = acc_q;
    k_d         = k_q;
    pend_full_d = pend_full_q;
    pend_d      = pend_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    ovf_d       = ovf_q;

    if ((state_q == S_EMPTY) && iData_Valid) begin
      prev_d = iData;
    end

    // Output k=0 is the base itself, so the accumulator is preloaded one step on.
    if (start) begin
      prev_d  = start_base;
      tgt_d   = start_new;
      delta_d = start_delta;
      acc_d   = {1'b0, start_base, {SHIFT{1'b0}}} +
                {{SHIFT{start_delta[8]}}, start_delta};
      k_d     = KW'(1);
      data_d  = start_base;
      valid_d = 1'b1;
    end else if (run_tail) begin
      prev_d  = tgt_q;
    end else if (state_q == S_RUN) begin
      data_d  = acc_q[SHIFT +: 8];
      valid_d = 1'b1;
      acc_d   = acc_q + {{SHIFT{delta_q[8]}}, delta_q};
      k_d     = k_q + KW'(1);
    end

    if (state_q == S_RUN) begin
      if (run_tail) begin
        if (pend_full_q) begin
          pend_full_d = 1'b0;
          if (iData_Valid) ovf_d = 1'b1;
        end
      end else if (iData_Valid) begin
        if (!pend_full_q) begin
          pend_full_d = 1'b1;
          pend_d      = iData;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  // Sign bit and fraction bits of the accumulator never reach the output.
  logic unused_acc;
  assign unused_acc = ^{acc_q[AW-1], acc_q[SHIFT-1:0]};

  assign oData       = data_q;
  assign oData_Valid = valid_q;
  assign oBusy       = (state_q == S_RUN) | pend_full_q;
  assign oOverflow   = ovf_q;

endmodule

`default_nettype wire
